// File: rtl/xmpl_dsp_pkg.sv
// -----------------------------------------------------------------------------
// xmpl_dsp_pkg
// Shared definitions for the DSP job arbiter: controller state encoding,
// operand/result widths, status bit positions and a saturating-increment
// helper for the timeout statistics counter.
// -----------------------------------------------------------------------------
package xmpl_dsp_pkg;

    localparam int DSP_OPW       = 12;  // operand width
    localparam int DSP_RESW      = 32;  // result / status width
    localparam int DSP_IDW       = 3;   // requester index width (up to 8 requesters)
    localparam int DSP_STAT_DONE = 0;   // dsp_status_i bit: job finished
    localparam int DSP_STAT_ERR  = 1;   // dsp_status_i bit: job failed

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } dsp_state_e;

    // Saturates at 255 rather than wrapping, so a long-running system never
    // reports a misleadingly small timeout count.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/xmpl_rr_arb.sv
// -----------------------------------------------------------------------------
// xmpl_rr_arb
// Purely combinational round-robin arbiter. The search starts at the index
// after last_grant_i and wraps around, so every requester is reached within
// NUM_REQ grants.
// Ports:
//   req_i        in   NUM_REQ  request vector
//   last_grant_i in   3        index of the previously granted requester
//   grant_o      out  NUM_REQ  one-hot grant (all-zero when no request)
//   grant_idx_o  out  3        binary index of the granted requester
// -----------------------------------------------------------------------------
module xmpl_rr_arb
    import xmpl_dsp_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [DSP_IDW-1:0] last_grant_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [DSP_IDW-1:0] grant_idx_o
);

    logic found;

    // Outer loop walks priority order (offset 1 = highest priority), inner loop
    // matches the rotated position against each constant requester index so
    // that no variable bit-select is needed.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && req_i[j] &&
                    (((int'(last_grant_i) + i) % NUM_REQ) == j)) begin
                    found       = 1'b1;
                    grant_o[j]  = 1'b1;
                    grant_idx_o = DSP_IDW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/xmpl_dsp_arb.sv
// -----------------------------------------------------------------------------
// xmpl_dsp_arb
// Shares one DSP engine between NUM_REQ requesters. One job at a time:
// IDLE grants a requester (round robin), ISSUE pulses dsp_start_o, WAIT waits
// for the DSP done bit or a timeout, RESP presents the result until accepted.
//
// Handshakes: a request transfers in a cycle where req_valid_i[g] and
// req_ready_o[g] are both high; a response transfers in a cycle where
// rsp_valid_o and rsp_ready_i are both high. Once raised, rsp_valid_o and all
// rsp_* outputs stay constant until that transfer happens.
//
// Ports:
//   clk_i, reset_n_i     clock, synchronous active-low reset
//   req_valid_i          per-requester job request
//   req_operand_i        per-requester 12-bit operand
//   req_ready_o          one-hot accept strobe (IDLE only)
//   dsp_start_o          one-cycle start pulse to the DSP
//   dsp_operand_o        captured operand (0 in IDLE)
//   dsp_result_i         DSP result
//   dsp_status_i         DSP status (bit0 done, bit1 error)
//   rsp_valid_o/ready_i  response handshake
//   rsp_id_o/data_o/err_o response payload
//   busy_o               state is not IDLE
//   timeout_cnt_o        saturating count of timed-out jobs
// -----------------------------------------------------------------------------
module xmpl_dsp_arb
    import xmpl_dsp_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic [NUM_REQ-1:0]                req_valid_i,
    input  logic [NUM_REQ-1:0][DSP_OPW-1:0]   req_operand_i,
    output logic [NUM_REQ-1:0]                req_ready_o,
    output logic                              dsp_start_o,
    output logic [DSP_OPW-1:0]                dsp_operand_o,
    input  logic [DSP_RESW-1:0]               dsp_result_i,
    input  logic [DSP_RESW-1:0]               dsp_status_i,
    output logic                              rsp_valid_o,
    input  logic                              rsp_ready_i,
    output logic [DSP_IDW-1:0]                rsp_id_o,
    output logic [DSP_RESW-1:0]               rsp_data_o,
    output logic                              rsp_err_o,
    output logic                              busy_o,
    output logic [7:0]                        timeout_cnt_o
);

    // TIMEOUT_CYC-1 always fits in $clog2(TIMEOUT_CYC) bits.
    localparam int                CNT_W    = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    dsp_state_e            state_q,       state_d;
    logic [DSP_IDW-1:0]    last_grant_q,  last_grant_d;
    logic [DSP_IDW-1:0]    id_q,          id_d;
    logic [DSP_OPW-1:0]    operand_q,     operand_d;
    logic [CNT_W-1:0]      wait_cnt_q,    wait_cnt_d;
    logic [DSP_RESW-1:0]   rsp_data_q,    rsp_data_d;
    logic                  rsp_err_q,     rsp_err_d;
    logic [7:0]            timeout_cnt_q, timeout_cnt_d;

    logic [NUM_REQ-1:0]    grant;
    logic [DSP_IDW-1:0]    grant_idx;
    logic                  dsp_done;
    logic                  dsp_err;
    logic [DSP_RESW-3:0]   unused_status;

    assign dsp_done      = dsp_status_i[DSP_STAT_DONE];
    assign dsp_err       = dsp_status_i[DSP_STAT_ERR];
    assign unused_status = dsp_status_i[DSP_RESW-1:2];

    xmpl_rr_arb #(
        .NUM_REQ      (NUM_REQ)
    ) u_rr_arb (
        .req_i        (req_valid_i),
        .last_grant_i (last_grant_q),
        .grant_o      (grant),
        .grant_idx_o  (grant_idx)
    );

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        id_d          = id_q;
        operand_d     = operand_q;
        wait_cnt_d    = wait_cnt_q;
        rsp_data_d    = rsp_data_q;
        rsp_err_d     = rsp_err_q;
        timeout_cnt_d = timeout_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (|req_valid_i) begin
                    state_d      = ST_ISSUE;
                    last_grant_d = grant_idx;
                    id_d         = grant_idx;
                    for (int j = 0; j < NUM_REQ; j++) begin
                        if (grant[j]) begin
                            operand_d = req_operand_i[j];
                        end
                    end
                end
            end
            ST_ISSUE: begin
                wait_cnt_d = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                // Done is tested first so a completion in the last allowed
                // cycle is reported normally and not counted as a timeout.
                if (dsp_done) begin
                    rsp_data_d = dsp_result_i;
                    rsp_err_d  = dsp_err;
                    state_d    = ST_RESP;
                end else if (wait_cnt_q == CNT_LAST) begin
                    rsp_data_d    = '0;
                    rsp_err_d     = 1'b1;
                    timeout_cnt_d = sat_inc8(timeout_cnt_q);
                    state_d       = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= DSP_IDW'(NUM_REQ - 1);  // first grant lands on 0
            id_q          <= '0;
            operand_q     <= '0;
            wait_cnt_q    <= '0;
            rsp_data_q    <= '0;
            rsp_err_q     <= 1'b0;
            timeout_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            id_q          <= id_d;
            operand_q     <= operand_d;
            wait_cnt_q    <= wait_cnt_d;
            rsp_data_q    <= rsp_data_d;
            rsp_err_q     <= rsp_err_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

    // req_ready_o is the only output fed combinationally by inputs, so it is
    // also masked by reset to keep every output quiet while reset is held.
    assign req_ready_o   = (state_q == ST_IDLE && reset_n_i) ? grant : '0;
    assign dsp_start_o   = (state_q == ST_ISSUE);
    assign dsp_operand_o = (state_q != ST_IDLE) ? operand_q : '0;
    assign rsp_valid_o   = (state_q == ST_RESP);
    assign rsp_id_o      = (state_q == ST_RESP) ? id_q : '0;
    assign rsp_data_o    = (state_q == ST_RESP) ? rsp_data_q : '0;
    assign rsp_err_o     = (state_q == ST_RESP) ? rsp_err_q : 1'b0;
    assign busy_o        = (state_q != ST_IDLE);
    assign timeout_cnt_o = timeout_cnt_q;

endmodule

// File: tb/tb_xmpl_dsp_arb.sv
// -----------------------------------------------------------------------------
// tb_xmpl_dsp_arb
// Directed bench for xmpl_dsp_arb (NUM_REQ=4, TIMEOUT_CYC=16). Stimulus tasks
// push the hand-computed response {id, err, data} into exp_q; a monitor pops
// and compares on every response transfer. Inputs change 2ns after a rising
// edge; outputs are inspected 1ns later or on the falling edge.
// -----------------------------------------------------------------------------
module tb_xmpl_dsp_arb;
    import xmpl_dsp_pkg::*;

    localparam int NR = 4;
    localparam int TO = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0][11:0] req_operand;
    logic [NR-1:0]     ready;
    logic              start;
    logic [11:0]       op;
    logic [31:0]       dsp_result;
    logic [31:0]       dsp_status;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [2:0]        rsp_id;
    logic [31:0]       rsp_data;
    logic              rsp_err;
    logic              busy;
    logic [7:0]        tocnt;

    xmpl_dsp_arb #(
        .NUM_REQ       (NR),
        .TIMEOUT_CYC   (TO)
    ) dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n),
        .req_valid_i   (req_valid),
        .req_operand_i (req_operand),
        .req_ready_o   (ready),
        .dsp_start_o   (start),
        .dsp_operand_o (op),
        .dsp_result_i  (dsp_result),
        .dsp_status_i  (dsp_status),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_id_o      (rsp_id),
        .rsp_data_o    (rsp_data),
        .rsp_err_o     (rsp_err),
        .busy_o        (busy),
        .timeout_cnt_o (tocnt)
    );

    // ---------------- scoreboard state ----------------
    int          n_pass  = 0;
    int          n_total = 0;
    logic [35:0] exp_q[$];
    int          grant_log[$];
    int          start_cnt = 0;
    logic [35:0] mon_exp;
    int          mon_gidx;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (|ready) begin
            check("ready_onehot", 64'($countones(ready)), 64'd1);
            mon_gidx = 0;
            for (int i = 0; i < NR; i++) if (ready[i]) mon_gidx = i;
            grant_log.push_back(mon_gidx);
        end
        if (start) start_cnt++;
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL rsp_unexpected: got id %0d data 0x%0h err %0b, expected no response",
                         rsp_id, rsp_data, rsp_err);
            end else begin
                mon_exp = exp_q.pop_front();
                check("rsp", {28'd0, rsp_id, rsp_err, rsp_data}, {28'd0, mon_exp});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_start(input string name);
        int i;
        i = 0;
        while (!start && i < 30) begin
            step();
            i++;
        end
        check({name, "_start"}, start, 1);
    endtask

    // Presents status/result for the current cycle; returns one cycle later.
    task automatic pulse_done(input logic [31:0] res, input logic [31:0] st);
        dsp_result = res;
        dsp_status = st;
        step();
        dsp_result = '0;
        dsp_status = '0;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = '1;
        repeat (3) step();
        #1;
        check("rst_ready", ready, 0);
        check("rst_ctrl", {start, rsp_valid, rsp_err, busy}, 0);
        check("rst_data", {op, rsp_id, rsp_data}, 0);
        check("rst_tocnt", tocnt, 0);
        req_valid = '0;
        reset_n   = 1'b1;
        step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_n     = 1'b0;
        req_valid   = '0;
        req_operand = '0;
        dsp_result  = '0;
        dsp_status  = '0;
        rsp_ready   = 1'b1;
        do_reset();

        // Single job on requester 2, done 3 cycles after start.
        req_operand[0] = 12'h111;
        req_operand[2] = 12'h0A5;
        req_valid      = 4'b0100;
        #1;
        check("t1_ready", ready, 4'b0100);
        check("t1_busy_idle", busy, 0);
        step();
        req_valid = '0;
        check("t1_start", start, 1);
        check("t1_operand", op, 12'h0A5);
        exp_q.push_back({3'd2, 1'b0, 32'hDEADBEEF});
        step();
        step();
        check("t1_single_start", start, 0);
        step();
        dsp_result = 32'hDEADBEEF;
        dsp_status = 32'h1;
        #1;
        check("t1_no_early_rsp", rsp_valid, 0);
        step();
        dsp_result = '0;
        dsp_status = '0;
        check("t1_rsp_valid", rsp_valid, 1);
        step();
        check("t1_back_idle", busy, 0);

        // All four requesters held valid: grants 0,1,2,3,0.
        do_reset();
        grant_log.delete();
        start_cnt   = 0;
        req_operand = {12'h0A3, 12'h0A2, 12'h0A1, 12'h0A0};
        req_valid   = 4'hF;
        for (int k = 0; k < 5; k++) begin
            wait_start("t2");
            check("t2_operand", op, 12'h0A0 + 12'(k % 4));
            exp_q.push_back({3'(k % 4), 1'b0, 32'h100 + 32'(k)});
            step();
            pulse_done(32'h100 + 32'(k), 32'h1);
            if (k == 4) req_valid = '0;
            step();
        end
        step();
        check("t2_grant_count", grant_log.size(), 5);
        for (int k = 0; k < 5 && k < grant_log.size(); k++)
            check("t2_grant_order", grant_log[k], k % 4);
        check("t2_start_count", start_cnt, 5);

        // Timeout; a done bit presented during ISSUE must be ignored.
        req_operand[1] = 12'h5A5;
        req_valid      = 4'b0010;
        #1;
        check("t3_ready", ready, 4'b0010);
        step();
        req_valid  = '0;
        check("t3_start", start, 1);
        dsp_result = 32'hBAD0BAD0;
        dsp_status = 32'h1;
        step();
        dsp_result = '0;
        dsp_status = '0;
        for (int k = 0; k < TO - 1; k++) step();
        #1;
        check("t3_not_yet", rsp_valid, 0);
        exp_q.push_back({3'd1, 1'b1, 32'h0});
        step();
        check("t3_rsp_valid", rsp_valid, 1);
        check("t3_tocnt", tocnt, 1);
        step();

        // Done in the final timeout cycle: normal response, count unchanged.
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        check("t4_start", start, 1);
        step();
        for (int k = 0; k < TO - 1; k++) step();
        exp_q.push_back({3'd0, 1'b0, 32'h12345678});
        pulse_done(32'h12345678, 32'h1);
        check("t4_rsp_valid", rsp_valid, 1);
        check("t4_tocnt", tocnt, 1);
        step();
        // Done with error bit: err reported together with the data.
        req_valid = 4'b1000;
        step();
        req_valid = '0;
        step();
        exp_q.push_back({3'd3, 1'b1, 32'hCAFEF00D});
        pulse_done(32'hCAFEF00D, 32'h3);
        check("t4_err", rsp_err, 1);
        step();
        // Upper status bits carry no meaning.
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        step();
        exp_q.push_back({3'd2, 1'b0, 32'h55});
        pulse_done(32'h55, 32'hFFFFFFFD);
        step();

        // Back-pressure: response held, no new grant while stalled.
        rsp_ready = 1'b0;
        req_valid = 4'b1000;
        step();
        req_valid = '0;
        step();
        exp_q.push_back({3'd3, 1'b0, 32'hA5A5A5A5});
        pulse_done(32'hA5A5A5A5, 32'h1);
        req_valid = 4'b1001;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("t5_hold", {rsp_valid, rsp_id, rsp_err, rsp_data}, {1'b1, 3'd3, 1'b0, 32'hA5A5A5A5});
            check("t5_no_grant", ready, 0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        #1;
        check("t5_grant_after", ready, 4'b0001);
        step();
        req_valid = '0;
        step();
        step();
        // Reset in WAIT: job aborted, no response, last grant restored.
        reset_n   = 1'b0;
        req_valid = 4'hF;
        #1;
        check("t5_rst_ready", ready, 0);
        step();
        check("t5_rst_ctrl", {start, rsp_valid, rsp_err, busy}, 0);
        check("t5_rst_data", {op, rsp_id, rsp_data}, 0);
        check("t5_rst_tocnt", tocnt, 0);
        step();
        reset_n = 1'b1;
        #1;
        check("t5_first_grant", ready, 4'b0001);
        step();
        req_valid = '0;
        exp_q.push_back({3'd0, 1'b0, 32'h77});
        step();
        pulse_done(32'h77, 32'h1);
        step();
        step();

        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/xmpl_dsp_arb.md
XMPL_DSP_ARB -- requirements
Module: xmpl_dsp_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1023, max WAIT cycles before abort (>=2).
REQ-003 SHALL use one clock; reset is synchronous and active-low.
- clk_i  in  1  clock; all logic on rising edge.
- reset_n_i  in  1  synchronous, active-low reset.
- req_valid_i  in  NUM_REQ  per-requester job request.
- req_operand_i  in  NUM_REQ x 12  per-requester operand.
- req_ready_o  out  NUM_REQ  one-hot accept strobe.
- dsp_start_o  out  1  one-cycle start pulse to the DSP FSM.
- dsp_operand_o  out  12  operand to the DSP FSM.
- dsp_result_i  in  32  DSP result.
- dsp_status_i  in  32  DSP status; bit0 = done, bit1 = error, others ignored.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response accept.
- rsp_id_o  out  3  index of the requester being answered.
- rsp_data_o  out  32  result.
- rsp_err_o  out  1  DSP error or timeout.
- busy_o  out  1  high when the state is not IDLE.
- timeout_cnt_o  out  8  saturating count of timeouts.

Function
REQ-004 SHALL implement the FSM states IDLE, ISSUE, WAIT and RESP.
REQ-005 In IDLE with any req_valid_i high, SHALL grant round-robin starting at last_grant+1 mod NUM_REQ.
- Assert req_ready_o[g] in the same cycle (combinational from registered state).
- Capture operand and id, update last_grant, go to ISSUE.
REQ-006 req_ready_o SHALL be all-zero in every state except IDLE; at most one bit SHALL be high.
REQ-007 ISSUE SHALL assert dsp_start_o for exactly one cycle, clear the wait counter and go to WAIT.
REQ-008 dsp_operand_o SHALL hold the captured operand from ISSUE until RESP exits; it SHALL be 0 in IDLE.
REQ-009 WAIT with dsp_status_i[0]=1 SHALL register rsp_data_o=dsp_result_i and rsp_err_o=dsp_status_i[1], then go to RESP.
REQ-010 WAIT without done SHALL increment the counter; when the counter reaches TIMEOUT_CYC-1, SHALL go to RESP with rsp_data_o=0, rsp_err_o=1 and timeout_cnt_o+1 (saturating at 255).
REQ-011 If done and timeout occur in the same cycle, done SHALL win and no timeout SHALL be counted.
REQ-012 RESP SHALL hold rsp_valid_o and all rsp_* outputs stable until rsp_ready_i=1, then go to IDLE; rsp_valid_o SHALL be 0 otherwise.
REQ-013 Minimum latency SHALL be: accept at cycle N, dsp_start_o at N+1, done sampled at N+2 or later, rsp_valid_o from the cycle after done.
REQ-014 Requests arriving while busy SHALL wait and SHALL NOT be dropped; fairness SHALL guarantee any held request is granted within NUM_REQ jobs.
REQ-015 A requester deasserting valid before grant SHALL lose nothing; no grant SHALL be given to a deasserted requester.
REQ-016 dsp_status_i SHALL be ignored outside WAIT.

Reset
REQ-017 reset_n_i=0 SHALL force the state to IDLE and last_grant=NUM_REQ-1 (first grant goes to index 0).
REQ-018 During reset, all outputs, the counter and timeout_cnt_o SHALL be 0.
REQ-019 Reset asserted mid-job SHALL abort the job without producing a response; the first post-reset cycle SHALL be IDLE.

Structure
REQ-020 Package xmpl_dsp_pkg SHALL hold:
- the state enum;
- DSP_OPW=12 and DSP_RESW=32;
- DSP_STAT_DONE=0 and DSP_STAT_ERR=1.
REQ-021 Sub-module xmpl_rr_arb SHALL implement the round-robin arbitration.
- Inputs: request vector, last_grant.
- Outputs: one-hot grant and index.
REQ-022 Target size SHALL be 150-300 RTL lines.

Verification
REQ-023 Single job: req_valid_i[2]=1, operand 0x0A5, done with result 0xDEADBEEF 3 cycles after start -> rsp_id_o=2, rsp_data_o=0xDEADBEEF, rsp_err_o=0.
REQ-024 All four requesters held valid continuously -> grants in order 0,1,2,3,0; exactly one dsp_start_o per job.
REQ-025 DSP never signals done, TIMEOUT_CYC=16 -> rsp_valid_o 16 cycles after entering WAIT with rsp_err_o=1 and rsp_data_o=0; timeout_cnt_o=1.
REQ-026 Done in the final timeout cycle -> normal response, timeout_cnt_o unchanged; status=0x3 with done -> rsp_err_o=1.
REQ-027 rsp_ready_i held 0 for 5 cycles -> rsp_* outputs stable and no new grant; then reset during WAIT -> all outputs 0 and the next grant goes to requester 0.
